// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector merge, exception/ERET flush
// sequencing and a saturating stall-cycle performance counter.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic        excp_is_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    input  logic        cnt_clr,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FLUSH
    } state_t;

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
        $error("pipe_ctrl: FLUSH_CYCLES must be within 1..4");
    end

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        flush_d;
    logic [31:0] new_pc_d;
    logic [5:0]  stall_req;

    // Highest requesting stage wins; bubbles are inserted downstream.
    always_comb begin
        stall_req = 6'b000000;
        priority case (1'b1)
            stallreq_mem: stall_req = 6'b011111;
            stallreq_ex:  stall_req = 6'b001111;
            stallreq_id:  stall_req = 6'b000111;
            stallreq_if:  stall_req = 6'b000011;
            default:      stall_req = 6'b000000;
        endcase
    end

    assign stall = (rst || state_q == FLUSH) ? 6'b000000 : stall_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tgt_q   <= 32'h0;
            fcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (excp_valid) begin
                    tgt_d = excp_is_eret ? cp0_epc : EXC_VECTOR;
                    if (stallreq_mem) begin
                        state_d = PEND;
                    end else begin
                        state_d = FLUSH;
                        fcnt_d  = FCNT_LOAD;
                    end
                end
            end
            PEND: begin
                if (!stallreq_mem) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush_d  = (state_d == FLUSH);
        new_pc_d = flush_d ? tgt_d : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush  <= 1'b0;
            new_pc <= 32'h0;
        end else begin
            flush  <= flush_d;
            new_pc <= new_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cycles <= 32'h0;
        end else if (stall[0] && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall table plus hand-written
// exception, ERET, long-flush, counter and reset sequences.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid, excp_is_eret;
    logic [31:0] cp0_epc;
    logic        cnt_clr;
    logic [5:0]  stall, stall3;
    logic        flush, flush3;
    logic [31:0] new_pc, new_pc3;
    logic [31:0] stall_cycles, stall_cycles3;

    int n_total = 0;
    int n_pass  = 0;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_is_eret(excp_is_eret),
        .cp0_epc(cp0_epc), .stall(stall), .flush(flush),
        .new_pc(new_pc), .cnt_clr(cnt_clr),
        .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid), .excp_is_eret(excp_is_eret),
        .cp0_epc(cp0_epc), .stall(stall3), .flush(flush3),
        .new_pc(new_pc3), .cnt_clr(cnt_clr),
        .stall_cycles(stall_cycles3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic quiet();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excp_valid   = 1'b0;
        excp_is_eret = 1'b0;
        cnt_clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{"if",      4'b0001, 6'b000011};
        vecs[1] = '{"id",      4'b0010, 6'b000111};
        vecs[2] = '{"ex",      4'b0100, 6'b001111};
        vecs[3] = '{"mem",     4'b1000, 6'b011111};
        vecs[4] = '{"id_mem",  4'b1010, 6'b011111};
        vecs[5] = '{"none",    4'b0000, 6'b000000};
        vecs[6] = '{"all",     4'b1111, 6'b011111};
        vecs[7] = '{"if_ex",   4'b0101, 6'b001111};

        rst = 1'b1;
        cp0_epc = 32'h0;
        quiet();
        stallreq_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_cnt", stall_cycles, 32'h0);
        rst = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = vecs[i].req;
            #1;
            chk({"tbl_", vecs[i].name}, 32'(stall), 32'(vecs[i].exp));
            @(negedge clk);
        end
        idle(2);

        // Exception with MEM idle
        excp_valid = 1'b1;
        @(negedge clk);
        excp_valid = 1'b0;
        stallreq_ex = 1'b1;
        #1;
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_new_pc", new_pc, 32'h20);
        chk("exc_stall0", 32'(stall), 32'h0);
        @(negedge clk);
        #1;
        chk("exc_flush_end", 32'(flush), 32'h0);
        chk("exc_new_pc_end", new_pc, 32'h0);
        chk("exc_stall_back", 32'(stall), 32'h0F);
        idle(6);

        // ERET with MEM stalled; second exception in PEND ignored
        cp0_epc = 32'hBFC0_0100;
        excp_valid = 1'b1;
        excp_is_eret = 1'b1;
        stallreq_mem = 1'b1;
        #1;
        chk("eret_stall_acc", 32'(stall), 32'h1F);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cp0_epc = 32'h0;
            excp_valid = (k == 0);
            excp_is_eret = 1'b0;
            #1;
            chk("eret_pend_stall", 32'(stall), 32'h1F);
            chk("eret_pend_flush", 32'(flush), 32'h0);
        end
        @(negedge clk);
        stallreq_mem = 1'b0;
        excp_valid = 1'b0;
        #1;
        chk("eret_nf_early", 32'(flush), 32'h0);
        @(negedge clk);
        #1;
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_new_pc", new_pc, 32'hBFC0_0100);
        @(negedge clk);
        #1;
        chk("eret_flush_end", 32'(flush), 32'h0);
        idle(6);

        // FLUSH_CYCLES=3 instance; excp_valid during flush ignored
        excp_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            excp_valid = (k <= 2);
            #1;
            chk("f3_flush", 32'(flush3), (k <= 3) ? 32'h1 : 32'h0);
            chk("f3_new_pc", new_pc3, (k <= 3) ? 32'h20 : 32'h0);
        end
        idle(6);

        // Stall-cycle counter
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        stallreq_id = 1'b1;
        #1;
        chk("cnt_zero", stall_cycles, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        chk("cnt_five", stall_cycles, 32'd5);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("cnt_clr", stall_cycles, 32'd0);
        @(negedge clk);
        #1;
        chk("cnt_after_clr", stall_cycles, 32'd1);
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        @(negedge clk);
        #1;
        chk("cnt_max", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        chk("cnt_sat", stall_cycles, 32'hFFFF_FFFF);
        idle(2);

        // Reset in PEND aborts the pending flush
        excp_valid = 1'b1;
        stallreq_mem = 1'b1;
        @(negedge clk);
        excp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rpend_flush", 32'(flush), 32'h0);
        chk("rpend_stall", 32'(stall), 32'h0);
        chk("rpend_cnt", stall_cycles, 32'h0);
        rst = 1'b0;
        #1;
        chk("rpend_idle_stall", 32'(stall), 32'h1F);
        @(negedge clk);
        stallreq_mem = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rpend_no_flush", 32'(flush), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector consumed by the PC register and all inter-stage latches. It also sequences exception/ERET flushes: it accepts an exception from MEM, waits for MEM to finish any outstanding access, then drives a registered flush pulse with the redirect PC. It also keeps a stall-cycle performance counter.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for all non-ERET exceptions
FLUSH_CYCLES, 1, cycles flush is held high (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if  in  1  IF stage waiting on instruction memory
stallreq_id  in  1  ID load-use hazard
stallreq_ex  in  1  EX multi-cycle op (div/madd) busy
stallreq_mem  in  1  MEM waiting on data memory
excp_valid  in  1  MEM-stage instruction raised exception or is ERET
excp_is_eret  in  1  qualifies excp_valid: 1 = ERET
cp0_epc  in  32  current CP0 EPC
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = stop
flush  out  1  clear all latches, load new_pc
new_pc  out  32  redirect target, valid while flush=1
cnt_clr  in  1  synchronous clear of stall_cycles
stall_cycles  out  32  count of cycles with stall[0]=1, saturating

Behaviour:
- Stall vector is combinational from the requests and state. Highest requesting stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- Bit k+1 low with bit k high means the latch after stage k inserts a bubble. Downstream latches already implement this.
- stall is forced to 6'b000000 while rst=1 and while state=FLUSH.
- FSM states: IDLE, PEND, FLUSH.
  - IDLE: excp_valid=1 and stallreq_mem=0 -> FLUSH. excp_valid=1 and stallreq_mem=1 -> PEND.
  - On either transition, latch the target: cp0_epc if excp_is_eret, else EXC_VECTOR.
  - PEND: hold the latched target. Ignore further excp_valid (first exception wins). When stallreq_mem=0 -> FLUSH. Stall keeps following the requests.
  - FLUSH: flush=1, new_pc=latched target, held exactly FLUSH_CYCLES cycles using a down-counter, then -> IDLE.
  - In FLUSH, all stallreq_* and excp_valid are ignored because they come from squashed instructions.
- flush and new_pc are registered. flush rises the cycle after the accepting edge (IDLE->FLUSH, or PEND->FLUSH). Exception-to-flush latency is 1 cycle when MEM is idle, else N+1 cycles, where N = cycles stallreq_mem stays high.
- new_pc is 0 whenever flush=0.
- stall_cycles:
  - Increments each cycle stall[0]=1.
  - Saturates at 32'hFFFF_FFFF.
  - cnt_clr has priority over increment; the counter reads 0 the next cycle.
- Reset values: stall=0, flush=0, new_pc=0, stall_cycles=0, state=IDLE, latched target=0, flush counter=0.
- Reset asserted mid-PEND or mid-FLUSH aborts immediately; the next cycle shows reset values.
- A simultaneous request on all four stallreq_* lines gives 6'b011111.
- FLUSH_CYCLES outside 1..4 is illegal; flag it with a simulation-time check.

Test Plan:
1. Single requests: stallreq_if only -> stall=000011; id -> 000111; ex -> 001111; mem -> 011111; id+mem together -> 011111; none -> 000000.
2. Exception while MEM is idle:
   - Stimulus: excp_valid=1, excp_is_eret=0 for one cycle at edge T.
   - Required: flush=1 and new_pc=32'h20 during cycle T+1 only; stall=0 during that cycle, even with stallreq_ex=1 applied.
3. ERET while MEM is stalled:
   - Stimulus: cp0_epc=32'hBFC0_0100, excp_valid=1, excp_is_eret=1, stallreq_mem=1 for 3 more cycles. Change cp0_epc to 0 and pulse excp_valid again during PEND.
   - Required: stall=011111 during those 3 cycles; flush 1 cycle after stallreq_mem drops, with new_pc=32'hBFC0_0100.
4. FLUSH_CYCLES=3: exception -> flush high exactly 3 consecutive cycles; excp_valid during flush is ignored (no second flush).
5. Counter:
   - 5 cycles of stallreq_id -> stall_cycles=5.
   - cnt_clr with stallreq_id still high -> 0 next cycle, then 1.
   - Force-preload to 32'hFFFF_FFFE with stall held -> counter stops at 32'hFFFF_FFFF.
6. Reset mid-operation: rst=1 in the cycle after entering PEND -> next cycle flush=0, stall=0, state IDLE. Releasing stallreq_mem after reset produces no flush.
